// File: rtl/fa_pkg.sv
// Shared full-adder types and cell equation.
//   fa_in_t  : one bit of operand A, one bit of operand B, carry in
//   fa_out_t : sum bit, carry out
//   fa_eval  : the single-bit full-adder equation. The cell uses it, and so
//              does any model that needs the same bundle semantics.
package fa_pkg;

  localparam int unsigned FA_WIDTH_MIN = 1;
  localparam int unsigned FA_WIDTH_MAX = 64;

  typedef struct packed {
    logic a;
    logic b;
    logic cin;
  } fa_in_t;

  typedef struct packed {
    logic sum;
    logic cout;
  } fa_out_t;

  function automatic fa_out_t fa_eval(input fa_in_t x);
    fa_out_t r;
    r.sum  = x.a ^ x.b ^ x.cin;
    r.cout = (x.a & x.b) | (x.a & x.cin) | (x.b & x.cin);
    return r;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Purely combinational 1-bit full adder on the fa bundle.
// Ports:
//   fa_in  : {a, b, cin}
//   fa_out : {sum, cout}
module fa_cell
  import fa_pkg::*;
(
  input  fa_in_t  fa_in,
  output fa_out_t fa_out
);

  always_comb begin
    fa_out = fa_eval(fa_in);
  end

endmodule

// File: rtl/fa_reg_adder.sv
// Registered WIDTH-bit ripple-carry adder built from fa_cell instances.
// The result appears one cycle after in_valid is sampled high.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous reset, active-high; has priority over in_valid
//   in_valid  : a/b/cin are valid this cycle
//   a, b      : WIDTH-bit unsigned operands
//   cin       : carry into bit 0
//   out_valid : sum/cout hold a fresh result
//   sum       : registered (a + b + cin) mod 2^WIDTH
//   cout      : registered carry out of bit WIDTH-1
module fa_reg_adder
  import fa_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa_in_t  cell_in;
    fa_out_t cell_out;

    assign cell_in = '{a: a[i], b: b[i], cin: carry[i]};

    fa_cell u_cell (
      .fa_in  (cell_in),
      .fa_out (cell_out)
    );

    assign sum_comb[i] = cell_out.sum;
    assign carry[i+1]  = cell_out.cout;
  end

  // Loading sum/cout only when in_valid is high makes idle cycles hold the
  // last result and keeps X on idle inputs out of the registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_comb;
        cout <= carry[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_fa_reg_adder.sv
module tb_fa_reg_adder;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid1, cin1, out_valid1, cout1;
  logic [0:0] a1, b1, sum1;

  logic       in_valid8, cin8, out_valid8, cout8;
  logic [7:0] a8, b8, sum8;

  always #5 clk = ~clk;

  fa_reg_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (out_valid1),
    .sum       (sum1),
    .cout      (cout1)
  );

  fa_reg_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .sum       (sum8),
    .cout      (cout8)
  );

  typedef struct {
    logic       v1;
    logic [0:0] s1;
    logic       c1;
    logic       v8;
    logic [7:0] s8;
    logic       c8;
  } exp_t;

  exp_t q[$];

  // Reference state: results hold across idle cycles, so the model does too.
  logic [0:0] m_s1 = '0;
  logic       m_c1 = 1'b0;
  logic [7:0] m_s8 = '0;
  logic       m_c8 = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input logic r,
                      input logic v1_i, input logic [0:0] a1_i, input logic [0:0] b1_i, input logic c1_i,
                      input logic v8_i, input logic [7:0] a8_i, input logic [7:0] b8_i, input logic c8_i,
                      input string tag);
    exp_t       e;
    logic [1:0] t1;
    logic [8:0] t8;
    exp_t       got;

    rst = r;
    in_valid1 = v1_i; a1 = a1_i; b1 = b1_i; cin1 = c1_i;
    in_valid8 = v8_i; a8 = a8_i; b8 = b8_i; cin8 = c8_i;

    if (r) begin
      m_s1 = '0; m_c1 = 1'b0; m_s8 = '0; m_c8 = 1'b0;
      e.v1 = 1'b0; e.v8 = 1'b0;
    end else begin
      e.v1 = v1_i;
      e.v8 = v8_i;
      if (v1_i) begin
        t1 = 2'(a1_i) + 2'(b1_i) + 2'(c1_i);
        {m_c1, m_s1} = t1;
      end
      if (v8_i) begin
        t8 = 9'(a8_i) + 9'(b8_i) + 9'(c8_i);
        {m_c8, m_s8} = t8;
      end
    end
    e.s1 = m_s1; e.c1 = m_c1; e.s8 = m_s8; e.c8 = m_c8;
    q.push_back(e);

    @(posedge clk);
    #1;
    e = q.pop_front();
    got.v1 = out_valid1; got.s1 = sum1; got.c1 = cout1;
    got.v8 = out_valid8; got.s8 = sum8; got.c8 = cout8;
    chk({tag, ".w1_valid"}, 9'(got.v1), 9'(e.v1));
    chk({tag, ".w1_sum"},   9'(got.s1), 9'(e.s1));
    chk({tag, ".w1_cout"},  9'(got.c1), 9'(e.c1));
    chk({tag, ".w8_valid"}, 9'(got.v8), 9'(e.v8));
    chk({tag, ".w8_sum"},   9'(got.s8), 9'(e.s8));
    chk({tag, ".w8_cout"},  9'(got.c8), 9'(e.c8));
  endtask

  initial begin
    logic [2:0] vec;

    // Reset state
    step(1'b1, 1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 8'hxx, 8'hxx, 1'bx, "reset0");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "reset1");

    // Directed vectors, including all-ones wrap-around on the 8-bit adder
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, "zero_wrap");
    chk("wrap_sum_const", 9'({cout8, sum8}), 9'h100);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 8'h3C, 1'b0, "ones_5a3c");
    chk("5a3c_sum_const", 9'({cout8, sum8}), 9'h096);
    chk("w1_111_const",   9'({cout1, sum1}), 9'h003);

    // Exhaustive 1-bit vectors back-to-back; 8-bit side gets random operands
    for (int unsigned i = 0; i < 8; i++) begin
      vec = 3'(i);
      step(1'b0, 1'b1, vec[2], vec[1], vec[0],
           1'b1, 8'($urandom), 8'($urandom), 1'($urandom), "b2b");
    end

    // Idle with X inputs: out_valid drops, sum/cout hold
    step(1'b0, 1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 8'hxx, 8'hxx, 1'bx, "idle_x0");
    step(1'b0, 1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 8'hxx, 8'hxx, 1'bx, "idle_x1");

    // Carry ripple through every bit
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h80, 8'h7F, 1'b1, "ripple");

    // Transaction coincident with reset is dropped; outputs stay cleared after
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h01, 1'b0, "rst_drop");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h01, 1'b1, "post_rst0");
    step(1'b0, 1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 8'hxx, 8'hxx, 1'bx, "post_rst1");

    // Random mix of valid and idle cycles
    for (int unsigned i = 0; i < 16; i++) begin
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
